// File: rtl/mul_raw_fn_iter_pkg.sv
// Shared definitions for the iterative recFN multiplier and its recFN decode helper.
// Holds the field widths, the raw-float record and the controller state encoding.
package mul_raw_fn_iter_pkg;

  localparam int EXP_W    = 8;
  localparam int SIG_W    = 24;
  localparam int REC_W    = 33;
  localparam int SEXP_W   = 10;
  localparam int RAWSIG_W = 27;
  localparam int PROD_W   = 2 * SIG_W;
  localparam int CNT_W    = 5;

  typedef struct packed {
    logic                is_nan;
    logic                is_inf;
    logic                is_zero;
    logic                sign;
    logic [SEXP_W-1:0]   s_exp;
    logic [RAWSIG_W-1:0] sig;
  } raw_fn_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

endpackage

// File: rtl/mul_raw_fn_iter_rec_fn_to_raw_fn.sv
// Combinational recFN (exp 8 / sig 24) field decode into classification flags and significand.
// Kept separate so other arithmetic stages can reuse the same decode.
module rec_fn_to_raw_fn
  import mul_raw_fn_iter_pkg::*;
(
  input  logic [REC_W-1:0] rec_in,
  output logic             is_nan,
  output logic             is_inf,
  output logic             is_zero,
  output logic             is_snan,
  output logic             sign,
  output logic [EXP_W:0]   exp,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-2:0] fract;
  logic             special;

  always_comb begin
    sign    = rec_in[REC_W-1];
    exp     = rec_in[REC_W-2:SIG_W-1];
    fract   = rec_in[SIG_W-2:0];
    is_zero = (exp[EXP_W:EXP_W-2] == 3'b000);
    special = (exp[EXP_W:EXP_W-1] == 2'b11);
    is_nan  = special & exp[EXP_W-2];
    is_inf  = special & ~exp[EXP_W-2];
    // The quiet bit is the top fraction bit; a NaN without it is signaling.
    is_snan = is_nan & ~fract[SIG_W-2];
    sig     = {~is_zero, fract};
  end

endmodule

// File: rtl/mul_raw_fn_iter.sv
// Iterative single-precision recFN multiplier producing an unrounded raw-FN product
// (27-bit sticky significand) behind ready/valid handshakes on both sides.
module mul_raw_fn_iter
  import mul_raw_fn_iter_pkg::*;
#(
  parameter int BITS_PER_CYCLE = 1
)
(
  input  logic              clock,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [32:0]       io_in_a,
  input  logic [32:0]       io_in_b,
  input  logic [2:0]        io_in_roundingMode,
  output logic              io_out_valid,
  input  logic              io_out_ready,
  output logic              io_out_invalidExc,
  output logic              io_out_isNaN,
  output logic              io_out_isInf,
  output logic              io_out_isZero,
  output logic              io_out_sign,
  output logic [9:0]        io_out_sExp,
  output logic [26:0]       io_out_sig,
  output logic [2:0]        io_out_roundingMode
);

  localparam int ITERS = SIG_W / BITS_PER_CYCLE;

  logic             a_nan, a_inf, a_zero, a_snan, a_sign;
  logic             b_nan, b_inf, b_zero, b_snan, b_sign;
  logic [EXP_W:0]   a_exp, b_exp;
  logic [SIG_W-1:0] a_sig, b_sig;

  rec_fn_to_raw_fn u_dec_a (
    .rec_in  (io_in_a),
    .is_nan  (a_nan),
    .is_inf  (a_inf),
    .is_zero (a_zero),
    .is_snan (a_snan),
    .sign    (a_sign),
    .exp     (a_exp),
    .sig     (a_sig)
  );

  rec_fn_to_raw_fn u_dec_b (
    .rec_in  (io_in_b),
    .is_nan  (b_nan),
    .is_inf  (b_inf),
    .is_zero (b_zero),
    .is_snan (b_snan),
    .sign    (b_sign),
    .exp     (b_exp),
    .sig     (b_sig)
  );

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROD_W-1:0] mcand_q, mcand_d;
  logic [SIG_W-1:0]  mplier_q, mplier_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  raw_fn_t           res_q, res_d;
  logic              invalid_q, invalid_d;
  logic [2:0]        rm_q, rm_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic              dec_invalid, dec_nan, dec_special;
  logic [PROD_W-1:0] partial;

  always_comb begin
    dec_invalid = a_snan | b_snan | (a_inf & b_zero) | (a_zero & b_inf);
    dec_nan     = a_nan | b_nan | dec_invalid;
    dec_special = a_nan | a_inf | a_zero | b_nan | b_inf | b_zero;

    partial = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mplier_q[i]) begin
        partial = partial + (mcand_q << i);
      end
    end

    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    res_d       = res_q;
    invalid_d   = invalid_q;
    rm_d        = rm_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (io_in_valid && in_ready_q) begin
          invalid_d     = dec_invalid;
          res_d.is_nan  = dec_nan;
          res_d.is_inf  = (a_inf | b_inf) & ~dec_nan;
          res_d.is_zero = (a_zero | b_zero) & ~dec_nan;
          res_d.sign    = a_sign ^ b_sign;
          res_d.s_exp   = {1'b0, a_exp} + {1'b0, b_exp} - 10'd256;
          res_d.sig     = '0;
          rm_d          = io_in_roundingMode;
          mcand_d       = {{(PROD_W-SIG_W){1'b0}}, a_sig};
          mplier_d      = b_sig;
          acc_d         = '0;
          cnt_d         = CNT_W'(ITERS - 1);
          in_ready_d    = 1'b0;
          state_d       = dec_special ? DONE : BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_q + partial;
        mcand_d  = mcand_q << BITS_PER_CYCLE;
        mplier_d = mplier_q >> BITS_PER_CYCLE;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // First DONE cycle registers the sticky significand; valid follows it.
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          res_d.sig   = {acc_q[PROD_W-1:PROD_W-RAWSIG_W+1], |acc_q[PROD_W-RAWSIG_W:0]};
        end else if (io_out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      res_q       <= '0;
      invalid_q   <= 1'b0;
      rm_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      res_q       <= res_d;
      invalid_q   <= invalid_d;
      rm_q        <= rm_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign io_in_ready         = in_ready_q;
  assign io_out_valid        = out_valid_q;
  assign io_out_invalidExc   = invalid_q;
  assign io_out_isNaN        = res_q.is_nan;
  assign io_out_isInf        = res_q.is_inf;
  assign io_out_isZero       = res_q.is_zero;
  assign io_out_sign         = res_q.sign;
  assign io_out_sExp         = res_q.s_exp;
  assign io_out_sig          = res_q.sig;
  assign io_out_roundingMode = rm_q;

endmodule

// File: tb/tb_mul_raw_fn_iter.sv
// Scoreboard bench for the iterative recFN multiplier: default instance plus a 4-bit-per-cycle one.
`timescale 1ns/1ps
module tb_mul_raw_fn_iter;

  localparam logic [32:0] ONE     = 33'h080000000;
  localparam logic [32:0] TWO     = 33'h080800000;
  localparam logic [32:0] P1_5    = 33'h080400000;
  localparam logic [32:0] M1_5    = 33'h180400000;
  localparam logic [32:0] INF     = 33'h0C0000000;
  localparam logic [32:0] ZERO    = 33'h000000000;
  localparam logic [32:0] SNAN    = 33'h0E0000000;
  localparam logic [32:0] QNAN    = 33'h0E0400000;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_in_valid, io_in_ready, io_out_valid, io_out_ready;
  logic [32:0] io_in_a, io_in_b;
  logic [2:0]  io_in_roundingMode, io_out_roundingMode;
  logic        io_out_invalidExc, io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign;
  logic [9:0]  io_out_sExp;
  logic [26:0] io_out_sig;

  logic        in4_valid, in4_ready, out4_valid, out4_ready;
  logic [32:0] in4_a, in4_b;
  logic [2:0]  in4_rm, out4_rm;
  logic        out4_inv, out4_nan, out4_inf, out4_zero, out4_sign;
  logic [9:0]  out4_sexp;
  logic [26:0] out4_sig;

  typedef struct {
    logic [44:0] vec;
    logic [44:0] mask;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb4_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 clock = ~clock;

  mul_raw_fn_iter dut (
    .clock(clock), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready),
    .io_in_a(io_in_a), .io_in_b(io_in_b), .io_in_roundingMode(io_in_roundingMode),
    .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .io_out_invalidExc(io_out_invalidExc), .io_out_isNaN(io_out_isNaN),
    .io_out_isInf(io_out_isInf), .io_out_isZero(io_out_isZero), .io_out_sign(io_out_sign),
    .io_out_sExp(io_out_sExp), .io_out_sig(io_out_sig),
    .io_out_roundingMode(io_out_roundingMode)
  );

  mul_raw_fn_iter #(.BITS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset),
    .io_in_valid(in4_valid), .io_in_ready(in4_ready),
    .io_in_a(in4_a), .io_in_b(in4_b), .io_in_roundingMode(in4_rm),
    .io_out_valid(out4_valid), .io_out_ready(out4_ready),
    .io_out_invalidExc(out4_inv), .io_out_isNaN(out4_nan),
    .io_out_isInf(out4_inf), .io_out_isZero(out4_zero), .io_out_sign(out4_sign),
    .io_out_sExp(out4_sexp), .io_out_sig(out4_sig),
    .io_out_roundingMode(out4_rm)
  );

  // Reference model written straight from the recFN field definitions.
  function automatic exp_t model(input logic [32:0] a, input logic [32:0] b,
                                 input logic [2:0] rm, input int bpc);
    exp_t        e;
    logic [8:0]  ea, eb;
    logic        za, zb, na, nb, ia, ib, sna, snb, inv, nan, inf, zero, spec;
    logic [47:0] prod;
    logic [9:0]  sexp;
    logic [26:0] sig;
    ea   = a[31:23];
    eb   = b[31:23];
    za   = (ea[8:6] == 3'b000);
    zb   = (eb[8:6] == 3'b000);
    na   = (ea[8:7] == 2'b11) && ea[6];
    nb   = (eb[8:7] == 2'b11) && eb[6];
    ia   = (ea[8:7] == 2'b11) && !ea[6];
    ib   = (eb[8:7] == 2'b11) && !eb[6];
    sna  = na && !a[22];
    snb  = nb && !b[22];
    inv  = sna | snb | (ia & zb) | (za & ib);
    nan  = na | nb | inv;
    inf  = (ia | ib) & !nan;
    zero = (za | zb) & !nan;
    spec = za | zb | na | nb | ia | ib;
    prod = {24'd0, !za, a[22:0]} * {24'd0, !zb, b[22:0]};
    sexp = {1'b0, ea} + {1'b0, eb} - 10'd256;
    sig  = {prod[47:22], |prod[21:0]};
    e.mask = spec ? {5'h1f, 37'h0, 3'h7} : {45{1'b1}};
    e.vec  = {inv, nan, inf, zero, a[32] ^ b[32], sexp, sig, rm} & e.mask;
    e.lat  = spec ? 1 : 24 / bpc + 1;
    return e;
  endfunction

  function automatic logic [44:0] obs_main();
    return {io_out_invalidExc, io_out_isNaN, io_out_isInf, io_out_isZero, io_out_sign,
            io_out_sExp, io_out_sig, io_out_roundingMode};
  endfunction

  function automatic logic [44:0] obs4();
    return {out4_inv, out4_nan, out4_inf, out4_zero, out4_sign, out4_sexp, out4_sig, out4_rm};
  endfunction

  // Waits (bounded) for the default instance to be ready, then issues one operation.
  task automatic applyStimulus(input logic [32:0] a, input logic [32:0] b, input logic [2:0] rm);
    int guard = 0;
    while (!io_in_ready && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    io_in_a            = a;
    io_in_b            = b;
    io_in_roundingMode = rm;
    io_in_valid        = 1'b1;
    sb_q.push_back(model(a, b, rm, 1));
    @(posedge clock); #1;
    io_in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!io_out_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic release_out();
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++;
    if ({io_in_ready, io_out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL reset_hs: got %b expected 10", {io_in_ready, io_out_valid});
    end
    checks++;
    if (obs_main() !== 45'h0) begin
      errors++;
      $display("[TB] FAIL reset_outs: got %h expected 0", obs_main());
    end
    checks++;
    if ({in4_ready, out4_valid, obs4()} !== {2'b10, 45'h0}) begin
      errors++;
      $display("[TB] FAIL reset_dut4: got %h expected %h", {in4_ready, out4_valid, obs4()},
               {2'b10, 45'h0});
    end
  endtask

  task automatic test_basic();
    logic [32:0] ta [2] = '{ONE, P1_5};
    logic [32:0] tb [2] = '{TWO, M1_5};
    logic [9:0]  tx [2] = '{10'h101, 10'h100};
    logic [26:0] ts [2] = '{27'h2000000, 27'h4800000};
    logic        tg [2] = '{1'b0, 1'b1};
    exp_t e;
    int   lat;
    for (int k = 0; k < 2; k++) begin
      applyStimulus(ta[k], tb[k], 3'(k * 3));
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 25) begin
        errors++;
        $display("[TB] FAIL basic_lat%0d: got %0d expected 25", k, lat);
      end
      checks++;
      if ((obs_main() & e.mask) !== e.vec) begin
        errors++;
        $display("[TB] FAIL basic_sb%0d: got %h expected %h", k, obs_main() & e.mask, e.vec);
      end
      checks++;
      if ({io_out_sExp, io_out_sig, io_out_sign, io_out_invalidExc, io_out_isNaN,
           io_out_isInf, io_out_isZero} !== {tx[k], ts[k], tg[k], 4'b0000}) begin
        errors++;
        $display("[TB] FAIL basic_const%0d: got sExp=%h sig=%h sign=%b expected sExp=%h sig=%h sign=%b",
                 k, io_out_sExp, io_out_sig, io_out_sign, tx[k], ts[k], tg[k]);
      end
      release_out();
      checks++;
      if ({io_in_ready, io_out_valid} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL basic_idle%0d: got %b expected 10", k, {io_in_ready, io_out_valid});
      end
    end
  endtask

  task automatic test_special();
    logic [32:0] ta [5] = '{INF, SNAN, QNAN, ZERO, INF};
    logic [32:0] tb [5] = '{ZERO, ONE, ONE, ONE, TWO};
    logic [3:0]  tf [5] = '{4'b1100, 4'b1100, 4'b0100, 4'b0001, 4'b0010};
    exp_t e;
    int   lat;
    for (int k = 0; k < 5; k++) begin
      applyStimulus(ta[k], tb[k], 3'd1);
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== 1) begin
        errors++;
        $display("[TB] FAIL special_lat%0d: got %0d expected 1", k, lat);
      end
      checks++;
      if ({io_out_invalidExc, io_out_isNaN, io_out_isInf, io_out_isZero} !== tf[k]) begin
        errors++;
        $display("[TB] FAIL special_flags%0d: got %b expected %b", k,
                 {io_out_invalidExc, io_out_isNaN, io_out_isInf, io_out_isZero}, tf[k]);
      end
      checks++;
      if ((obs_main() & e.mask) !== e.vec) begin
        errors++;
        $display("[TB] FAIL special_sb%0d: got %h expected %h", k, obs_main() & e.mask, e.vec);
      end
      release_out();
    end
  endtask

  task automatic test_random();
    logic [32:0] a, b;
    exp_t e;
    int   lat;
    for (int k = 0; k < 8; k++) begin
      a = {1'($urandom_range(0, 1)), 9'($urandom_range(64, 383)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 9'($urandom_range(64, 383)), 23'($urandom)};
      applyStimulus(a, b, 3'($urandom_range(0, 4)));
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== e.lat || (obs_main() & e.mask) !== e.vec) begin
        errors++;
        $display("[TB] FAIL random%0d: got lat=%0d %h expected lat=%0d %h", k, lat,
                 obs_main() & e.mask, e.lat, e.vec);
      end
      release_out();
    end
  endtask

  task automatic test_backpressure();
    logic [44:0] held;
    exp_t e;
    int   lat;
    applyStimulus(P1_5, M1_5, 3'd4);
    wait_valid(lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 25 || (obs_main() & e.mask) !== e.vec) begin
      errors++;
      $display("[TB] FAIL bp_first: got lat=%0d %h expected lat=25 %h", lat, obs_main(), e.vec);
    end
    held = obs_main();
    io_in_a     = ONE;
    io_in_b     = TWO;
    io_in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock); #1;
      checks++;
      if (obs_main() !== held || {io_in_ready, io_out_valid} !== 2'b01) begin
        errors++;
        $display("[TB] FAIL bp_hold%0d: got %h rdy/vld=%b expected %h rdy/vld=01", k,
                 obs_main(), {io_in_ready, io_out_valid}, held);
      end
    end
    io_in_valid = 1'b0;
    release_out();
    checks++;
    if ({io_in_ready, io_out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bp_release: got %b expected 10", {io_in_ready, io_out_valid});
    end
    applyStimulus(ONE, TWO, 3'd2);
    wait_valid(lat);
    e = sb_q.pop_front();
    checks++;
    if (lat !== 25 || (obs_main() & e.mask) !== e.vec) begin
      errors++;
      $display("[TB] FAIL bp_next: got lat=%0d %h expected lat=25 %h", lat, obs_main(), e.vec);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [32:0] ta [3] = '{INF, ONE, P1_5};
    logic [32:0] tb [3] = '{ZERO, TWO, P1_5};
    exp_t e;
    int   lat;
    io_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(ta[k], tb[k], 3'(k));
      wait_valid(lat);
      e = sb_q.pop_front();
      checks++;
      if (lat !== e.lat || (obs_main() & e.mask) !== e.vec) begin
        errors++;
        $display("[TB] FAIL b2b%0d: got lat=%0d %h expected lat=%0d %h", k, lat,
                 obs_main() & e.mask, e.lat, e.vec);
      end
      @(posedge clock); #1;
      checks++;
      if ({io_in_ready, io_out_valid} !== 2'b10) begin
        errors++;
        $display("[TB] FAIL b2b_idle%0d: got %b expected 10", k, {io_in_ready, io_out_valid});
      end
    end
    io_out_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    logic seen = 1'b0;
    applyStimulus(ONE, TWO, 3'd0);
    void'(sb_q.pop_back());
    repeat (9) begin
      @(posedge clock); #1;
    end
    checks++;
    if ({io_in_ready, io_out_valid} !== 2'b00) begin
      errors++;
      $display("[TB] FAIL rst_busy_pre: got %b expected 00", {io_in_ready, io_out_valid});
    end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if ({io_in_ready, io_out_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL rst_busy_post: got %b expected 10", {io_in_ready, io_out_valid});
    end
    io_out_ready = 1'b1;
    repeat (40) begin
      @(posedge clock); #1;
      if (io_out_valid) seen = 1'b1;
    end
    io_out_ready = 1'b0;
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_busy_spurious: got valid=1 expected no result");
    end
  endtask

  task automatic test_bpc4();
    exp_t e;
    int   lat = 0;
    checks++;
    if (in4_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bpc4_ready: got %b expected 1", in4_ready);
    end
    in4_a     = ONE;
    in4_b     = TWO;
    in4_rm    = 3'd3;
    in4_valid = 1'b1;
    sb4_q.push_back(model(ONE, TWO, 3'd3, 4));
    @(posedge clock); #1;
    in4_valid = 1'b0;
    while (!out4_valid && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    e = sb4_q.pop_front();
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("[TB] FAIL bpc4_lat: got %0d expected 7", lat);
    end
    checks++;
    if ({out4_sexp, out4_sig} !== {10'h101, 27'h2000000} || (obs4() & e.mask) !== e.vec) begin
      errors++;
      $display("[TB] FAIL bpc4_result: got %h expected %h", obs4(), e.vec);
    end
    out4_ready = 1'b1;
    @(posedge clock); #1;
    out4_ready = 1'b0;
    checks++;
    if ({in4_ready, out4_valid} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL bpc4_idle: got %b expected 10", {in4_ready, out4_valid});
    end
  endtask

  initial begin
    reset              = 1'b1;
    io_in_valid        = 1'b0;
    io_out_ready       = 1'b0;
    io_in_a            = '0;
    io_in_b            = '0;
    io_in_roundingMode = '0;
    in4_valid          = 1'b0;
    out4_ready         = 1'b0;
    in4_a              = '0;
    in4_b              = '0;
    in4_rm             = '0;
    test_reset();
    test_basic();
    test_special();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_busy();
    test_bpc4();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

endmodule
